seq_alu_unit: RTL and testbench
===============================

Name: seq_alu_unit

Overview:
Parametrised, clocked successor to the combinational switch-driven ALU. It holds operands A and B in registers loaded from switch data and executes an operation on a start strobe. Multi-cycle operations (iterative multiply, bit-serial shift) run under a busy/done handshake. A registered display mux drives the LED bank, and the block sits between board switch debouncers and the LED output.

Parameters:
WIDTH, 8, operand width in bits; legal range 4..16.
LED_W, 8, LED bank width; the display mux zero-pads or truncates its source to LED_W.

Ports:
seq_alu_unit_clk_xi  in  1  system clock; all state updates on the rising edge.
seq_alu_unit_rst_xi  in  1  reset, asynchronous, active-high.
seq_alu_unit_data_xi  in  WIDTH  operand data from the switches.
seq_alu_unit_load_a_xi  in  1  capture data_xi into A.
seq_alu_unit_load_b_xi  in  1  capture data_xi into B.
seq_alu_unit_op_xi  in  3  operation code, sampled with start.
seq_alu_unit_start_xi  in  1  start strobe.
seq_alu_unit_disp_sel_xi  in  3  LED source select.
seq_alu_unit_busy_xo  out  1  operation in progress.
seq_alu_unit_done_xo  out  1  one-cycle completion pulse.
seq_alu_unit_result_xo  out  2*WIDTH  registered result.
seq_alu_unit_flags_xo  out  4  {err, ovf, carry, zero}.
seq_alu_unit_led_xo  out  LED_W  registered LED pattern.

Behaviour:
- Reset: A, B, result, flags, led, busy and done all clear to 0; FSM enters IDLE. Reset asserted mid-operation aborts the operation with no done pulse.
- Operand loads:
  - Loads are accepted only while busy=0.
  - If load_a and load_b are both high in the same cycle, both registers take data_xi.
  - A load in the same cycle as an accepted start captures the new value, but the op uses the old A/B.
- Op codes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL (unsigned).
- Result width rules:
  - ADD/SUB/logic: result[WIDTH-1:0] holds the value; the upper half is 0.
  - MUL: full 2*WIDTH product.
  - Shifts: amount = B[clog2(WIDTH)-1:0]; result is WIDTH bits, zero-filled.
- FSM states: IDLE, EXEC, DONE.
  - IDLE -> EXEC when start=1; op, A and B are latched into working registers.
  - EXEC lasts L cycles with busy=1. L=1 for codes 0-4, L=WIDTH for MUL (shift-add, one bit per cycle), L=max(amount,1) for shifts (one position per cycle).
  - EXEC -> DONE: result and flags are updated and done=1 for exactly one cycle; busy=0 in DONE.
  - DONE -> IDLE unconditionally. A start in the DONE cycle is accepted, i.e. DONE -> EXEC for back-to-back operation.
- start while busy is ignored; it is not queued.
- Flags, updated only at DONE:
  - zero: full result == 0.
  - carry: ADD carry-out; SUB borrow (A<B unsigned); last bit shifted out for shifts; 0 otherwise.
  - ovf: signed two's-complement overflow for ADD/SUB; product exceeds WIDTH bits for MUL; 0 otherwise.
  - err: 0 unless the optional feature defines otherwise.
- Display mux, registered (one-cycle lag after a source change):
  - disp_sel 0: A. 1: B. 2: result low half. 3: result high half.
  - 4: {flags, busy, done} zero-extended.
  - 5-7: all zeros.

Optional Feature:
SEQ_ALU_UNIT_DIV_EN.
- Defined: op 7 becomes restoring unsigned division. MUL moves to the alternate encoding selected when disp_sel_xi[2]=1 at start. Division takes WIDTH cycles; quotient goes to result low, remainder to result high. B=0 gives quotient all-ones, remainder A, err=1, latency 1.
- Undefined: op 7 is always MUL, disp_sel_xi at start is ignored, and err is constant 0.

Decomposition:
- Package seq_alu_pkg:
  - op-code localparams;
  - FSM state encoding;
  - disp_sel codes;
  - flag bit indices.
- One sub-module, seq_alu_iter_core, holds the iterative datapath (shift-add multiply, bit-serial shift, optional divider) with its counter, and returns a valid pulse. The top keeps the operand registers, FSM, flags and display mux.

Test Plan:
- WIDTH=8, A=200, B=100, ADD -> result 0x002C, carry=1, ovf=0, zero=0; done exactly 2 cycles after start.
- A=5, B=7, SUB -> result 0x00FE, carry=1; A=B=0x80, SUB -> zero=1, carry=0.
- A=15, B=17, MUL -> result 0x00FF, ovf=0. A=255, B=255 -> 0xFE01, ovf=1. busy high for 8 cycles, one done pulse.
- Shifts: A=0x81, B=3, SHL -> result 0x0008, carry=0, busy 3 cycles. B=0, SHR -> result 0x0081, latency 1.
- Busy protection: pulse start during MUL -> ignored; load_a during busy -> A unchanged; start in the DONE cycle -> second op runs back-to-back.
- Reset: assert reset mid-MUL -> busy, done, result and led go to 0 immediately with no done pulse. With SEQ_ALU_UNIT_DIV_EN, op 7, A=100, B=7 -> quotient 14, remainder 2; B=0 -> err=1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// ---------------------------------------------------------------------------
// seq_alu_pkg
// Shared definitions for the sequential ALU: operation codes, FSM state
// encoding, display-select codes and flag bit positions.
// Optional build macro used by the including modules: SEQ_ALU_UNIT_DIV_EN.
// ---------------------------------------------------------------------------
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] DISP_A      = 3'd0;
  localparam logic [2:0] DISP_B      = 3'd1;
  localparam logic [2:0] DISP_RES_LO = 3'd2;
  localparam logic [2:0] DISP_RES_HI = 3'd3;
  localparam logic [2:0] DISP_STATUS = 3'd4;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;

endpackage

// File: rtl/seq_alu_iter_core.sv
// ---------------------------------------------------------------------------
// seq_alu_iter_core
// Working-register datapath of the sequential ALU. Latches op and operands
// on i_start, then steps once per cycle under a down-counter; o_valid is high
// during the final step, with o_result/o_carry/o_ovf/o_err showing that
// step's outcome so the caller can register it on the same edge.
// Ports:
//   i_clk, i_rst           clock, async active-high reset
//   i_start                latch operation (must only pulse while idle)
//   i_op, i_a, i_b         operation code and operands
//   i_div                  op 7 runs as division (SEQ_ALU_UNIT_DIV_EN only)
//   o_valid                last step of the running operation
//   o_result, o_carry, o_ovf, o_err   outcome of the last step
// Build macro: SEQ_ALU_UNIT_DIV_EN adds the restoring divider.
// ---------------------------------------------------------------------------
module seq_alu_iter_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [2:0]         i_op,
`ifdef SEQ_ALU_UNIT_DIV_EN
  input  logic               i_div,
`endif
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_valid,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_err
);

  localparam int AW = $clog2(WIDTH);
  localparam int CW = $clog2(2*WIDTH) + 1;

  logic               r_active;
  logic [2:0]         r_op;
  logic               r_bypass;   // shift by 0 or divide by 0: single no-op step
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;        // shifter / dividend-quotient
  logic [WIDTH-1:0]   r_b;        // multiplier (shifts right) / divisor
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;

  logic [AW-1:0]      w_amt;
  logic [CW-1:0]      w_len;
  logic               w_bypass;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_a_nxt;
  logic [WIDTH-1:0]   w_b_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_mcand_nxt;

`ifdef SEQ_ALU_UNIT_DIV_EN
  logic               r_div;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_nxt;
  logic               w_q;
  logic               w_is_div_start;
`endif

  // operation length and bypass decision, taken from the start-time inputs
  always_comb begin
    w_amt    = i_b[AW-1:0];
    w_len    = CW'(1);
    w_bypass = 1'b0;
    if (i_op == OP_SHL || i_op == OP_SHR) begin
      w_bypass = (w_amt == '0);
      w_len    = w_bypass ? CW'(1) : CW'(w_amt);
    end else if (i_op == OP_MUL) begin
      w_len = CW'(WIDTH);
`ifdef SEQ_ALU_UNIT_DIV_EN
      w_is_div_start = i_div;
      if (i_div && i_b == '0) begin
        w_bypass = 1'b1;
        w_len    = CW'(1);
      end
`endif
    end
  end

  always_comb begin
    w_sum       = '0;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_mcand_nxt = r_mcand;
    o_result    = '0;
    o_carry     = 1'b0;
    o_ovf       = 1'b0;
    o_err       = 1'b0;
`ifdef SEQ_ALU_UNIT_DIV_EN
    w_rem_sh  = '0;
    w_rem_nxt = '0;
    w_q       = 1'b0;
`endif
    case (r_op)
      OP_ADD: begin
        w_sum    = {1'b0, r_a} + {1'b0, r_b};
        o_result = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        o_carry  = w_sum[WIDTH];
        o_ovf    = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        // the 9th bit of the widened difference is the unsigned borrow
        w_sum    = {1'b0, r_a} - {1'b0, r_b};
        o_result = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        o_carry  = w_sum[WIDTH];
        o_ovf    = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: o_result = {{WIDTH{1'b0}}, r_a & r_b};
      OP_OR:  o_result = {{WIDTH{1'b0}}, r_a | r_b};
      OP_XOR: o_result = {{WIDTH{1'b0}}, r_a ^ r_b};
      OP_SHL: begin
        if (!r_bypass) begin
          w_a_nxt = r_a << 1;
          o_carry = r_a[WIDTH-1];
        end
        o_result = {{WIDTH{1'b0}}, w_a_nxt};
      end
      OP_SHR: begin
        if (!r_bypass) begin
          w_a_nxt = r_a >> 1;
          o_carry = r_a[0];
        end
        o_result = {{WIDTH{1'b0}}, w_a_nxt};
      end
      default: begin
`ifdef SEQ_ALU_UNIT_DIV_EN
        if (r_div) begin
          if (r_bypass) begin
            o_result = {r_a, {WIDTH{1'b1}}};
            o_err    = 1'b1;
          end else begin
            w_rem_sh = {r_rem, r_a[WIDTH-1]};
            w_q      = (w_rem_sh >= {1'b0, r_b});
            w_rem_nxt = w_q ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
            w_a_nxt  = {r_a[WIDTH-2:0], w_q};
            o_result = {w_rem_nxt[WIDTH-1:0], w_a_nxt};
          end
        end else begin
`endif
          w_acc_nxt   = r_acc + (r_b[0] ? r_mcand : '0);
          w_mcand_nxt = r_mcand << 1;
          w_b_nxt     = r_b >> 1;
          o_result    = w_acc_nxt;
          o_ovf       = |w_acc_nxt[2*WIDTH-1:WIDTH];
`ifdef SEQ_ALU_UNIT_DIV_EN
        end
`endif
      end
    endcase
  end

  assign o_valid = r_active && (r_cnt == CW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_op     <= OP_ADD;
      r_bypass <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
`ifdef SEQ_ALU_UNIT_DIV_EN
      r_div    <= 1'b0;
      r_rem    <= '0;
`endif
    end else if (i_start) begin
      r_active <= 1'b1;
      r_op     <= i_op;
      r_bypass <= w_bypass;
      r_cnt    <= w_len;
      r_a      <= i_a;
      r_b      <= i_b;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
`ifdef SEQ_ALU_UNIT_DIV_EN
      r_div    <= w_is_div_start;
      r_rem    <= '0;
`endif
    end else if (r_active) begin
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_mcand <= w_mcand_nxt;
      r_cnt   <= r_cnt - CW'(1);
`ifdef SEQ_ALU_UNIT_DIV_EN
      r_rem   <= w_rem_nxt[WIDTH-1:0];
`endif
      if (o_valid) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu_unit.sv
// ---------------------------------------------------------------------------
// seq_alu_unit
// Clocked ALU between the switch debouncers and the LED bank. Holds operands
// A/B, runs one operation per start strobe under a busy/done handshake and
// drives a registered LED display mux.
// Ports:
//   seq_alu_unit_clk_xi / _rst_xi   clock, async active-high reset
//   seq_alu_unit_data_xi            switch data (WIDTH)
//   seq_alu_unit_load_a_xi / _b_xi  load A / B from data (ignored while busy)
//   seq_alu_unit_op_xi              op code, sampled with start
//   seq_alu_unit_start_xi           start strobe
//   seq_alu_unit_disp_sel_xi        LED source select
//   seq_alu_unit_busy_xo / _done_xo handshake
//   seq_alu_unit_result_xo          result (2*WIDTH)
//   seq_alu_unit_flags_xo           {err, ovf, carry, zero}
//   seq_alu_unit_led_xo             LED pattern (LED_W)
// Build macro: SEQ_ALU_UNIT_DIV_EN -- op 7 divides; MUL is op 7 with
// disp_sel_xi[2]=1 at start.
//
// state   | meaning
// IDLE    | waiting for start
// EXEC    | iterative core running, busy=1
// DONE    | result/flags just updated, done=1; start here chains the next op
// ---------------------------------------------------------------------------
module seq_alu_unit
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LED_W = 8
) (
  input  logic               seq_alu_unit_clk_xi,
  input  logic               seq_alu_unit_rst_xi,
  input  logic [WIDTH-1:0]   seq_alu_unit_data_xi,
  input  logic               seq_alu_unit_load_a_xi,
  input  logic               seq_alu_unit_load_b_xi,
  input  logic [2:0]         seq_alu_unit_op_xi,
  input  logic               seq_alu_unit_start_xi,
  input  logic [2:0]         seq_alu_unit_disp_sel_xi,
  output logic               seq_alu_unit_busy_xo,
  output logic               seq_alu_unit_done_xo,
  output logic [2*WIDTH-1:0] seq_alu_unit_result_xo,
  output logic [3:0]         seq_alu_unit_flags_xo,
  output logic [LED_W-1:0]   seq_alu_unit_led_xo
);

  localparam int SW0 = (LED_W > WIDTH) ? LED_W : WIDTH;
  localparam int SW  = (SW0 > 6) ? SW0 : 6;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_result;
  logic [3:0]         r_flags;
  logic [LED_W-1:0]   r_led;
  logic               w_busy;
  logic               w_done;
  logic               w_accept;
  logic               w_core_valid;
  logic [2*WIDTH-1:0] w_core_res;
  logic               w_core_carry;
  logic               w_core_ovf;
  logic               w_core_err;
  logic [SW-1:0]      w_src;

  always_ff @(posedge seq_alu_unit_clk_xi or posedge seq_alu_unit_rst_xi) begin
    if (seq_alu_unit_rst_xi) r_state <= ST_IDLE;
    else                     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (seq_alu_unit_start_xi) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_busy = 1'b1;
        if (w_core_valid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (seq_alu_unit_start_xi) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // the core snapshots r_a/r_b on the accepting edge, so a same-cycle load
  // updates the registers without affecting the operation being started
  seq_alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_clk    (seq_alu_unit_clk_xi),
    .i_rst    (seq_alu_unit_rst_xi),
    .i_start  (w_accept),
    .i_op     (seq_alu_unit_op_xi),
`ifdef SEQ_ALU_UNIT_DIV_EN
    .i_div    (!seq_alu_unit_disp_sel_xi[2]),
`endif
    .i_a      (r_a),
    .i_b      (r_b),
    .o_valid  (w_core_valid),
    .o_result (w_core_res),
    .o_carry  (w_core_carry),
    .o_ovf    (w_core_ovf),
    .o_err    (w_core_err)
  );

  always_ff @(posedge seq_alu_unit_clk_xi or posedge seq_alu_unit_rst_xi) begin
    if (seq_alu_unit_rst_xi) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (!w_busy) begin
        if (seq_alu_unit_load_a_xi) r_a <= seq_alu_unit_data_xi;
        if (seq_alu_unit_load_b_xi) r_b <= seq_alu_unit_data_xi;
      end
      if (w_core_valid) begin
        r_result            <= w_core_res;
        r_flags[FLAG_ZERO]  <= (w_core_res == '0);
        r_flags[FLAG_CARRY] <= w_core_carry;
        r_flags[FLAG_OVF]   <= w_core_ovf;
        r_flags[FLAG_ERR]   <= w_core_err;
      end
    end
  end

  always_comb begin
    w_src = '0;
    case (seq_alu_unit_disp_sel_xi)
      DISP_A:      w_src = SW'(r_a);
      DISP_B:      w_src = SW'(r_b);
      DISP_RES_LO: w_src = SW'(r_result[WIDTH-1:0]);
      DISP_RES_HI: w_src = SW'(r_result[2*WIDTH-1:WIDTH]);
      DISP_STATUS: w_src = SW'({r_flags, w_busy, w_done});
      default:     w_src = '0;
    endcase
  end

  always_ff @(posedge seq_alu_unit_clk_xi or posedge seq_alu_unit_rst_xi) begin
    if (seq_alu_unit_rst_xi) r_led <= '0;
    else                     r_led <= w_src[LED_W-1:0];
  end

  assign seq_alu_unit_busy_xo   = w_busy;
  assign seq_alu_unit_done_xo   = w_done;
  assign seq_alu_unit_result_xo = r_result;
  assign seq_alu_unit_flags_xo  = r_flags;
  assign seq_alu_unit_led_xo    = r_led;

endmodule

// File: tb/tb_seq_alu_unit.sv
module tb_seq_alu_unit;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        load_a;
  logic        load_b;
  logic [2:0]  op;
  logic        start;
  logic [2:0]  disp_sel;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags;
  logic [7:0]  led;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu_unit #(.WIDTH(8), .LED_W(8)) dut (
    .seq_alu_unit_clk_xi      (clk),
    .seq_alu_unit_rst_xi      (rst),
    .seq_alu_unit_data_xi     (data),
    .seq_alu_unit_load_a_xi   (load_a),
    .seq_alu_unit_load_b_xi   (load_b),
    .seq_alu_unit_op_xi       (op),
    .seq_alu_unit_start_xi    (start),
    .seq_alu_unit_disp_sel_xi (disp_sel),
    .seq_alu_unit_busy_xo     (busy),
    .seq_alu_unit_done_xo     (done),
    .seq_alu_unit_result_xo   (result),
    .seq_alu_unit_flags_xo    (flags),
    .seq_alu_unit_led_xo      (led)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    data = a; load_a = 1'b1; tick(); load_a = 1'b0;
    data = b; load_b = 1'b1; tick(); load_b = 1'b0;
  endtask

  // pulses start and returns once done is seen (or the bound expires);
  // lat counts cycles from the start edge to the done cycle
  task automatic run_op(input logic [2:0] o, input logic alt, output int lat, output int busy_n);
    bit ok;
    op = o; disp_sel = alt ? 3'd4 : 3'd0; start = 1'b1;
    tick();
    start = 1'b0; lat = 1; busy_n = 0; ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin ok = 1; break; end
      if (busy) busy_n++;
      tick();
      lat++;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL done_timeout op=%0d got=no_done exp=done", o); end
  endtask

  task automatic test_reset;
    rst = 1'b1; data = '0; load_a = 0; load_b = 0; op = '0; start = 0; disp_sel = '0;
    #12;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_handshake got=%b%b exp=00", busy, done); end
    checks++; if (result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
    checks++; if (flags !== 4'h0 || led !== 8'h00) begin failures++; $display("FAIL reset_flags_led got=%h/%h exp=0/00", flags, led); end
    @(negedge clk); rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || result !== 16'h0000) begin failures++; $display("FAIL post_reset got=%b/%h exp=0/0000", busy, result); end
  endtask

  task automatic test_add;
    int lat, bn;
    load_ab(8'd200, 8'd100);
    run_op(OP_ADD, 1'b0, lat, bn);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (result !== 16'h002C) begin failures++; $display("FAIL add_result got=%h exp=002c", result); end
    checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL add_flags got=%b exp=0010", flags); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", done); end
    disp_sel = 3'd4; tick();
    checks++; if (led !== 8'h08) begin failures++; $display("FAIL disp_status got=%h exp=08", led); end
    disp_sel = 3'd0; tick();
    checks++; if (led !== 8'hC8) begin failures++; $display("FAIL disp_a got=%h exp=c8", led); end
    disp_sel = 3'd1; tick();
    checks++; if (led !== 8'h64) begin failures++; $display("FAIL disp_b got=%h exp=64", led); end
    disp_sel = 3'd6; tick();
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL disp_zero got=%h exp=00", led); end
  endtask

  task automatic test_sub;
    int lat, bn;
    load_ab(8'd5, 8'd7);
    run_op(OP_SUB, 1'b0, lat, bn);
    checks++; if (result !== 16'h00FE || flags !== 4'b0010) begin failures++; $display("FAIL sub_borrow got=%h/%b exp=00fe/0010", result, flags); end
    load_ab(8'h80, 8'h80);
    run_op(OP_SUB, 1'b0, lat, bn);
    checks++; if (result !== 16'h0000 || flags !== 4'b0001) begin failures++; $display("FAIL sub_zero got=%h/%b exp=0000/0001", result, flags); end
  endtask

  task automatic test_logic;
    int lat, bn;
    load_ab(8'hF0, 8'h3C);
    run_op(OP_AND, 1'b0, lat, bn);
    checks++; if (result !== 16'h0030) begin failures++; $display("FAIL and_result got=%h exp=0030", result); end
    run_op(OP_OR, 1'b0, lat, bn);
    checks++; if (result !== 16'h00FC) begin failures++; $display("FAIL or_result got=%h exp=00fc", result); end
    run_op(OP_XOR, 1'b0, lat, bn);
    checks++; if (result !== 16'h00CC || flags !== 4'b0000) begin failures++; $display("FAIL xor_result got=%h/%b exp=00cc/0000", result, flags); end
  endtask

  task automatic test_mul;
    int lat, bn;
    load_ab(8'd15, 8'd17);
    run_op(OP_MUL, 1'b1, lat, bn);
    checks++; if (result !== 16'h00FF || flags !== 4'b0000) begin failures++; $display("FAIL mul_small got=%h/%b exp=00ff/0000", result, flags); end
    checks++; if (bn !== 8) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=8", bn); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
    load_ab(8'd255, 8'd255);
    run_op(OP_MUL, 1'b1, lat, bn);
    checks++; if (result !== 16'hFE01 || flags !== 4'b0100) begin failures++; $display("FAIL mul_ovf got=%h/%b exp=fe01/0100", result, flags); end
    disp_sel = 3'd3; tick();
    checks++; if (led !== 8'hFE) begin failures++; $display("FAIL disp_res_hi got=%h exp=fe", led); end
  endtask

  task automatic test_shift;
    int lat, bn;
    load_ab(8'h81, 8'd3);
    run_op(OP_SHL, 1'b0, lat, bn);
    checks++; if (result !== 16'h0008 || flags !== 4'b0000) begin failures++; $display("FAIL shl3 got=%h/%b exp=0008/0000", result, flags); end
    checks++; if (bn !== 3) begin failures++; $display("FAIL shl3_busy got=%0d exp=3", bn); end
    load_ab(8'h81, 8'd0);
    run_op(OP_SHR, 1'b0, lat, bn);
    checks++; if (result !== 16'h0081 || lat !== 2) begin failures++; $display("FAIL shr0 got=%h/lat%0d exp=0081/lat2", result, lat); end
    load_ab(8'h81, 8'd1);
    run_op(OP_SHR, 1'b0, lat, bn);
    checks++; if (result !== 16'h0040 || flags !== 4'b0010) begin failures++; $display("FAIL shr1 got=%h/%b exp=0040/0010", result, flags); end
  endtask

  task automatic test_busy_protect;
    int lat;
    bit ok;
    load_ab(8'd3, 8'd4);
    op = OP_MUL; disp_sel = 3'd4; start = 1'b1; tick(); start = 1'b0;
    tick();
    op = OP_ADD; start = 1'b1; data = 8'h55; load_a = 1'b1; tick();
    start = 1'b0; load_a = 1'b0; op = OP_MUL;
    lat = 3; ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin ok = 1; break; end
      tick(); lat++;
    end
    checks++; if (!ok || lat !== 9) begin failures++; $display("FAIL busy_start_ignored got=lat%0d exp=lat9", lat); end
    checks++; if (result !== 16'h000C) begin failures++; $display("FAIL busy_mul_result got=%h exp=000c", result); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL busy_not_queued got=%b%b exp=00", busy, done); end
    disp_sel = 3'd0; tick();
    checks++; if (led !== 8'h03) begin failures++; $display("FAIL busy_load_a_blocked got=%h exp=03", led); end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    bit ok;
    load_ab(8'd10, 8'd3);
    run_op(OP_ADD, 1'b0, lat, bn);
    checks++; if (result !== 16'h000D) begin failures++; $display("FAIL b2b_first got=%h exp=000d", result); end
    op = OP_SUB; start = 1'b1; data = 8'd20; load_a = 1'b1; tick();
    start = 1'b0; load_a = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    lat = 1; ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin ok = 1; break; end
      tick(); lat++;
    end
    checks++; if (!ok || lat !== 2 || result !== 16'h0007) begin failures++; $display("FAIL b2b_second got=%h/lat%0d exp=0007/lat2", result, lat); end
    disp_sel = 3'd0; tick();
    checks++; if (led !== 8'd20) begin failures++; $display("FAIL b2b_load_a got=%h exp=14", led); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    load_ab(8'd255, 8'd255);
    op = OP_MUL; disp_sel = 3'd4; start = 1'b1; tick(); start = 1'b0;
    disp_sel = 3'd2; tick(); tick();
    checks++; if (busy !== 1'b1 || led !== 8'h07) begin failures++; $display("FAIL midrst_pre got=%b/%h exp=1/07", busy, led); end
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_handshake got=%b%b exp=00", busy, done); end
    checks++; if (result !== 16'h0000 || led !== 8'h00) begin failures++; $display("FAIL midrst_result_led got=%h/%h exp=0000/00", result, led); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0", seen); end
  endtask

`ifdef SEQ_ALU_UNIT_DIV_EN
  task automatic test_div;
    int lat, bn;
    load_ab(8'd100, 8'd7);
    run_op(OP_MUL, 1'b0, lat, bn);
    checks++; if (result !== 16'h020E || flags !== 4'b0000) begin failures++; $display("FAIL div_result got=%h/%b exp=020e/0000", result, flags); end
    checks++; if (bn !== 8) begin failures++; $display("FAIL div_busy got=%0d exp=8", bn); end
    load_ab(8'd100, 8'd0);
    run_op(OP_MUL, 1'b0, lat, bn);
    checks++; if (result !== 16'h64FF || flags !== 4'b1000 || lat !== 2) begin failures++; $display("FAIL div_zero got=%h/%b/lat%0d exp=64ff/1000/lat2", result, flags, lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_shift();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_ALU_UNIT_DIV_EN
    test_div();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
